// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: EX-stage operand forwarding and hazard detection.
// Picks a forwarding source for each EX operand (MEM, WB or a completing
// multi-cycle result), raises stall/bubble on load-use, pending multi-cycle
// RAW, multi-cycle WAW and scoreboard-full, tracks outstanding multi-cycle
// writes in a small scoreboard, and counts stall cycles with saturation.
module fwd_hazard_unit #(
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned LAT_W   = 4,
  parameter int unsigned CNT_W   = 32
) (
  input  logic                        CLK,
  input  logic                        RSTn,
  input  logic                        ex_valid,
  input  logic [NUM_SRC*REG_AW-1:0]   ex_rs,
  input  logic [NUM_SRC-1:0]          ex_rs_used,
  input  logic [REG_AW-1:0]           ex_rd,
  input  logic                        ex_wen,
  input  logic                        mc_issue,
  input  logic [LAT_W-1:0]            mc_lat,
  input  logic [REG_AW-1:0]           mem_rd,
  input  logic                        mem_wen,
  input  logic                        mem_is_load,
  input  logic [REG_AW-1:0]           wb_rd,
  input  logic                        wb_wen,
  output logic [NUM_SRC*3-1:0]        fwd_sel,
  output logic                        mc_done,
  output logic [REG_AW-1:0]           mc_done_rd,
  output logic                        stall,
  output logic                        bubble,
  output logic                        sb_full,
  output logic [CNT_W-1:0]            stall_cnt
);

  // Scoreboard state: one entry per outstanding multi-cycle write.
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [REG_AW-1:0] rd_q  [DEPTH];
  logic [REG_AW-1:0] rd_d  [DEPTH];
  logic [LAT_W-1:0]  cnt_q [DEPTH];
  logic [LAT_W-1:0]  cnt_d [DEPTH];
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic [DEPTH-1:0]   doneOh;
  logic               doneSeen;
  logic [REG_AW-1:0]  doneRd;
  logic [NUM_SRC-1:0] srcLoadUse;
  logic [NUM_SRC-1:0] srcRawPend;
  logic               loadUse;
  logic               rawPend;
  logic               wawHit;
  logic               stallRaw;
  logic               allocReq;
  logic               allocDone;
  logic [LAT_W-1:0]   allocCnt;

  // Only the lowest-index entry that has reached zero completes; others at zero wait their turn.
  always_comb begin
    doneOh   = '0;
    doneSeen = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (valid_q[i] && (cnt_q[i] == '0) && !doneSeen) begin
        doneOh[i] = 1'b1;
        doneSeen  = 1'b1;
      end
    end
  end

  // Destination register of the completing entry, zero when nothing completes.
  always_comb begin
    doneRd = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (doneOh[i]) doneRd = doneRd | rd_q[i];
    end
  end

  assign mc_done    = doneSeen;
  assign mc_done_rd = doneRd;
  assign sb_full    = &valid_q;

  // Per-source matching: forwarding select, load-use and pending multi-cycle RAW.
  for (genvar s = 0; s < int'(NUM_SRC); s++) begin : g_src
    logic [REG_AW-1:0] srcReg;
    logic              srcLive;
    logic              memHit;
    logic              wbHit;
    logic              mcHit;
    logic              pendHit;

    assign srcReg  = ex_rs[s*REG_AW +: REG_AW];
    assign srcLive = ex_rs_used[s] && (srcReg != '0);
    assign memHit  = srcLive && mem_wen && (mem_rd == srcReg);
    assign wbHit   = srcLive && wb_wen && (wb_rd == srcReg);
    assign mcHit   = srcLive && doneSeen && (doneRd == srcReg);

    // A source is blocked by any still-counting entry writing the same register.
    always_comb begin
      pendHit = 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (srcLive && valid_q[i] && (cnt_q[i] != '0) && (rd_q[i] == srcReg)) pendHit = 1'b1;
      end
    end

    assign fwd_sel[s*3 +: 3] = memHit ? 3'b010 :
                               wbHit  ? 3'b001 :
                               mcHit  ? 3'b100 : 3'b000;
    assign srcLoadUse[s] = memHit && mem_is_load;
    assign srcRawPend[s] = pendHit;
  end

  assign loadUse = |srcLoadUse;
  assign rawPend = |srcRawPend;

  // A younger writer must not overtake an outstanding multi-cycle write to the same register.
  always_comb begin
    wawHit = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (ex_wen && (ex_rd != '0) && valid_q[i] && (rd_q[i] == ex_rd)) wawHit = 1'b1;
    end
  end

  assign stallRaw = ex_valid && (loadUse || rawPend || wawHit || (mc_issue && sb_full));
  assign stall    = stallRaw;
  assign bubble   = stallRaw;

  assign allocReq = ex_valid && mc_issue && !stallRaw && (ex_rd != '0);
  assign allocCnt = (mc_lat == '0) ? '0 : (mc_lat - LAT_W'(1));

  // Scoreboard update: retire the completing entry, count down the rest, then allocate into the lowest free slot.
  always_comb begin
    valid_d   = valid_q;
    rd_d      = rd_q;
    cnt_d     = cnt_q;
    allocDone = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (doneOh[i]) begin
        valid_d[i] = 1'b0;
      end else if (valid_q[i] && (cnt_q[i] != '0)) begin
        cnt_d[i] = cnt_q[i] - LAT_W'(1);
      end
    end
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (allocReq && !allocDone && !valid_d[i]) begin
        valid_d[i] = 1'b1;
        rd_d[i]    = ex_rd;
        cnt_d[i]   = allocCnt;
        allocDone  = 1'b1;
      end
    end
  end

  // Stall counter sticks at all-ones instead of wrapping.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stallRaw && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  assign stall_cnt = stall_cnt_q;

  // State registers with synchronous active-low reset that drops all outstanding entries.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      valid_q     <= '0;
      stall_cnt_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        rd_q[i]  <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      valid_q     <= valid_d;
      stall_cnt_q <= stall_cnt_d;
      for (int i = 0; i < int'(DEPTH); i++) begin
        rd_q[i]  <= rd_d[i];
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit: directed scenarios plus randomized traffic for
// fwd_hazard_unit, checked against a ready-time based reference model.
module tb_fwd_hazard_unit;

  localparam int AW = 5;
  localparam int NS = 2;
  localparam int DP = 4;
  localparam int LW = 4;
  localparam int CW = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic              CLK = 1'b0;
  logic              RSTn = 1'b0;
  logic              ex_valid;
  logic [NS*AW-1:0]  ex_rs;
  logic [NS-1:0]     ex_rs_used;
  logic [AW-1:0]     ex_rd;
  logic              ex_wen;
  logic              mc_issue;
  logic [LW-1:0]     mc_lat;
  logic [AW-1:0]     mem_rd;
  logic              mem_wen;
  logic              mem_is_load;
  logic [AW-1:0]     wb_rd;
  logic              wb_wen;
  logic [NS*3-1:0]   fwd_sel;
  logic              mc_done;
  logic [AW-1:0]     mc_done_rd;
  logic              stall;
  logic              bubble;
  logic              sb_full;
  logic [CW-1:0]     stall_cnt;

  int total = 0;
  int bad   = 0;

  fwd_hazard_unit #(
    .REG_AW (AW),
    .NUM_SRC(NS),
    .DEPTH  (DP),
    .LAT_W  (LW),
    .CNT_W  (CW)
  ) dut (
    .CLK        (CLK),
    .RSTn       (RSTn),
    .ex_valid   (ex_valid),
    .ex_rs      (ex_rs),
    .ex_rs_used (ex_rs_used),
    .ex_rd      (ex_rd),
    .ex_wen     (ex_wen),
    .mc_issue   (mc_issue),
    .mc_lat     (mc_lat),
    .mem_rd     (mem_rd),
    .mem_wen    (mem_wen),
    .mem_is_load(mem_is_load),
    .wb_rd      (wb_rd),
    .wb_wen     (wb_wen),
    .fwd_sel    (fwd_sel),
    .mc_done    (mc_done),
    .mc_done_rd (mc_done_rd),
    .stall      (stall),
    .bubble     (bubble),
    .sb_full    (sb_full),
    .stall_cnt  (stall_cnt)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 CLK = ~CLK;

  // Reference model: each outstanding op remembers the absolute cycle its result becomes ready.
  bit            mValid [DP];
  logic [AW-1:0] mRd    [DP];
  int            mReady [DP];
  int            mStallCnt = 0;
  int            cycleNow  = 0;

  typedef struct {
    logic [NS*3-1:0] sel;
    logic            stall;
    logic            done;
    logic [AW-1:0]   doneRd;
    logic            full;
    int              doneSlot;
  } ExpT;

  // Expected outputs for the current cycle from the model state and the driven inputs.
  function automatic ExpT modelEval();
    ExpT e;
    logic [AW-1:0] rs;
    logic live, memM, lu, raw, waw;
    e.sel = '0; e.done = 1'b0; e.doneRd = '0; e.doneSlot = -1; e.full = 1'b1;
    lu = 1'b0; raw = 1'b0; waw = 1'b0;
    for (int i = 0; i < DP; i++) begin
      if (!mValid[i]) e.full = 1'b0;
      if (mValid[i] && cycleNow >= mReady[i] && !e.done) begin
        e.done = 1'b1; e.doneRd = mRd[i]; e.doneSlot = i;
      end
    end
    for (int s = 0; s < NS; s++) begin
      rs   = ex_rs[s*AW +: AW];
      live = ex_rs_used[s] && (rs != 0);
      memM = live && mem_wen && (mem_rd == rs);
      if (memM) e.sel[s*3 +: 3] = 3'b010;
      else if (live && wb_wen && wb_rd == rs) e.sel[s*3 +: 3] = 3'b001;
      else if (live && e.done && e.doneRd == rs) e.sel[s*3 +: 3] = 3'b100;
      if (memM && mem_is_load) lu = 1'b1;
      for (int i = 0; i < DP; i++)
        if (live && mValid[i] && cycleNow < mReady[i] && mRd[i] == rs) raw = 1'b1;
    end
    for (int i = 0; i < DP; i++)
      if (ex_wen && ex_rd != 0 && mValid[i] && mRd[i] == ex_rd) waw = 1'b1;
    e.stall = ex_valid && (lu || raw || waw || (mc_issue && e.full));
    return e;
  endfunction

  // Advance the model on every rising edge using the same inputs the DUT sees.
  always @(posedge CLK) begin
    ExpT e;
    bit placed;
    e = modelEval();
    if (!RSTn) begin
      for (int i = 0; i < DP; i++) mValid[i] = 1'b0;
      mStallCnt = 0;
    end else begin
      if (e.stall && mStallCnt < CNT_MAX) mStallCnt = mStallCnt + 1;
      if (e.done) mValid[e.doneSlot] = 1'b0;
      if (ex_valid && mc_issue && !e.stall && ex_rd != 0) begin
        placed = 1'b0;
        for (int i = 0; i < DP; i++) begin
          if (!placed && !mValid[i]) begin
            mValid[i] = 1'b1;
            mRd[i]    = ex_rd;
            mReady[i] = cycleNow + ((mc_lat == 0) ? 1 : int'(mc_lat));
            placed    = 1'b1;
          end
        end
      end
    end
    cycleNow = cycleNow + 1;
  end

  // Drive every functional input to its inactive value.
  task automatic idle();
    ex_valid = 1'b0; ex_rs = '0; ex_rs_used = '0; ex_rd = '0; ex_wen = 1'b0;
    mc_issue = 1'b0; mc_lat = '0; mem_rd = '0; mem_wen = 1'b0; mem_is_load = 1'b0;
    wb_rd = '0; wb_wen = 1'b0;
  endtask

  // Present a multi-cycle issue for one cycle.
  task automatic issueMc(input logic [AW-1:0] rd, input logic [LW-1:0] lat);
    idle();
    ex_valid = 1'b1; mc_issue = 1'b1; ex_wen = 1'b1; ex_rd = rd; mc_lat = lat;
  endtask

  task automatic test_reset();
    RSTn = 1'b0; idle();
    @(negedge CLK); @(negedge CLK);
    RSTn = 1'b1; #1;
    total++; if (fwd_sel !== 6'b0) begin bad++; $display("[TB] FAIL reset_fwd_sel got=%b want=%b", fwd_sel, 6'b0); end
    total++; if (mc_done !== 1'b0) begin bad++; $display("[TB] FAIL reset_mc_done got=%b want=0", mc_done); end
    total++; if (mc_done_rd !== 5'd0) begin bad++; $display("[TB] FAIL reset_mc_done_rd got=%0d want=0", mc_done_rd); end
    total++; if (sb_full !== 1'b0) begin bad++; $display("[TB] FAIL reset_sb_full got=%b want=0", sb_full); end
    total++; if (stall_cnt !== 4'd0) begin bad++; $display("[TB] FAIL reset_stall_cnt got=%0d want=0", stall_cnt); end
    total++; if (stall !== 1'b0) begin bad++; $display("[TB] FAIL reset_stall got=%b want=0", stall); end
    @(negedge CLK);
    mem_rd = 5'd7; mem_wen = 1'b1; mem_is_load = 1'b1; ex_rs = {5'd0, 5'd7}; ex_rs_used = 2'b01;
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("[TB] FAIL invalid_ex_no_stall got=%b want=0", stall); end
    total++; if (fwd_sel !== 6'b000010) begin bad++; $display("[TB] FAIL invalid_ex_fwd got=%b want=000010", fwd_sel); end
  endtask

  task automatic test_priority();
    @(negedge CLK);
    idle();
    ex_valid = 1'b1; ex_rs = {5'd5, 5'd5}; ex_rs_used = 2'b11;
    mem_rd = 5'd5; mem_wen = 1'b1; wb_rd = 5'd5; wb_wen = 1'b1;
    #1;
    total++; if (fwd_sel !== 6'b010010) begin bad++; $display("[TB] FAIL prio_mem got=%b want=010010", fwd_sel); end
    total++; if (stall !== 1'b0) begin bad++; $display("[TB] FAIL prio_mem_stall got=%b want=0", stall); end
    mem_rd = 5'd0; #1;
    total++; if (fwd_sel !== 6'b001001) begin bad++; $display("[TB] FAIL prio_wb got=%b want=001001", fwd_sel); end
    ex_rs = '0; #1;
    total++; if (fwd_sel !== 6'b000000) begin bad++; $display("[TB] FAIL prio_x0 got=%b want=000000", fwd_sel); end
    ex_rs = {5'd5, 5'd5}; ex_rs_used = 2'b10; #1;
    total++; if (fwd_sel !== 6'b001000) begin bad++; $display("[TB] FAIL prio_unused got=%b want=001000", fwd_sel); end
  endtask

  task automatic test_load_use();
    int c0;
    @(negedge CLK);
    idle();
    ex_valid = 1'b1; ex_rs = {5'd7, 5'd3}; ex_rs_used = 2'b11;
    mem_rd = 5'd7; mem_wen = 1'b1; mem_is_load = 1'b1;
    #1;
    c0 = mStallCnt;
    total++; if (stall !== 1'b1) begin bad++; $display("[TB] FAIL lu_stall got=%b want=1", stall); end
    total++; if (bubble !== 1'b1) begin bad++; $display("[TB] FAIL lu_bubble got=%b want=1", bubble); end
    total++; if (fwd_sel[5:3] !== 3'b010) begin bad++; $display("[TB] FAIL lu_fwd got=%b want=010", fwd_sel[5:3]); end
    @(negedge CLK);
    mem_wen = 1'b0; mem_is_load = 1'b0; wb_rd = 5'd7; wb_wen = 1'b1;
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("[TB] FAIL lu_release got=%b want=0", stall); end
    total++; if (fwd_sel[5:3] !== 3'b001) begin bad++; $display("[TB] FAIL lu_wb_fwd got=%b want=001", fwd_sel[5:3]); end
    total++; if (int'(stall_cnt) !== c0 + 1) begin bad++; $display("[TB] FAIL lu_stall_cnt got=%0d want=%0d", stall_cnt, c0 + 1); end
  endtask

  task automatic test_mc_raw();
    @(negedge CLK);
    issueMc(5'd9, 4'd3); #1;
    total++; if (stall !== 1'b0) begin bad++; $display("[TB] FAIL raw_issue_stall got=%b want=0", stall); end
    for (int k = 0; k < 2; k++) begin
      @(negedge CLK);
      idle(); ex_valid = 1'b1; ex_rs = {5'd0, 5'd9}; ex_rs_used = 2'b01; ex_wen = 1'b1; ex_rd = 5'd10;
      #1;
      total++; if (stall !== 1'b1) begin bad++; $display("[TB] FAIL raw_pending_stall cyc=%0d got=%b want=1", k, stall); end
    end
    @(negedge CLK); #1;
    total++; if (stall !== 1'b0) begin bad++; $display("[TB] FAIL raw_done_stall got=%b want=0", stall); end
    total++; if (mc_done !== 1'b1) begin bad++; $display("[TB] FAIL raw_mc_done got=%b want=1", mc_done); end
    total++; if (mc_done_rd !== 5'd9) begin bad++; $display("[TB] FAIL raw_mc_done_rd got=%0d want=9", mc_done_rd); end
    total++; if (fwd_sel[2:0] !== 3'b100) begin bad++; $display("[TB] FAIL raw_fwd_mc got=%b want=100", fwd_sel[2:0]); end
    @(negedge CLK);
    ex_rd = 5'd9; #1;
    total++; if (mc_done !== 1'b0) begin bad++; $display("[TB] FAIL raw_freed_done got=%b want=0", mc_done); end
    total++; if (stall !== 1'b0) begin bad++; $display("[TB] FAIL raw_freed_waw got=%b want=0", stall); end
    total++; if (fwd_sel[2:0] !== 3'b000) begin bad++; $display("[TB] FAIL raw_freed_fwd got=%b want=000", fwd_sel[2:0]); end
  endtask

  task automatic test_waw_full();
    int nDone;
    for (int k = 1; k <= 4; k++) begin
      @(negedge CLK);
      issueMc(AW'(k), 4'd15); #1;
      total++; if (stall !== 1'b0) begin bad++; $display("[TB] FAIL full_issue%0d_stall got=%b want=0", k, stall); end
    end
    @(negedge CLK); idle(); #1;
    total++; if (sb_full !== 1'b1) begin bad++; $display("[TB] FAIL full_sb_full got=%b want=1", sb_full); end
    @(negedge CLK); issueMc(5'd5, 4'd2); #1;
    total++; if (stall !== 1'b1) begin bad++; $display("[TB] FAIL full_fifth_stall got=%b want=1", stall); end
    @(negedge CLK); idle(); ex_valid = 1'b1; ex_wen = 1'b1; ex_rd = 5'd2; #1;
    total++; if (stall !== 1'b1) begin bad++; $display("[TB] FAIL waw_stall got=%b want=1", stall); end
    nDone = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge CLK); idle(); #1;
      if (mc_done === 1'b1) begin
        nDone++;
        total++; if (int'(mc_done_rd) !== nDone) begin bad++; $display("[TB] FAIL drain_order got=%0d want=%0d", mc_done_rd, nDone); end
      end
    end
    total++; if (nDone !== 4) begin bad++; $display("[TB] FAIL drain_count got=%0d want=4", nDone); end
    total++; if (sb_full !== 1'b0) begin bad++; $display("[TB] FAIL drain_sb_full got=%b want=0", sb_full); end
  endtask

  task automatic test_back_to_back();
    @(negedge CLK); issueMc(5'd11, 4'd3); #1;
    total++; if (stall !== 1'b0) begin bad++; $display("[TB] FAIL b2b_issue_a got=%b want=0", stall); end
    @(negedge CLK); issueMc(5'd12, 4'd2); #1;
    total++; if (stall !== 1'b0) begin bad++; $display("[TB] FAIL b2b_issue_b got=%b want=0", stall); end
    @(negedge CLK); idle(); #1;
    total++; if (mc_done !== 1'b0) begin bad++; $display("[TB] FAIL b2b_early_done got=%b want=0", mc_done); end
    @(negedge CLK); #1;
    total++; if (mc_done !== 1'b1 || mc_done_rd !== 5'd11) begin bad++; $display("[TB] FAIL b2b_first got=%b/%0d want=1/11", mc_done, mc_done_rd); end
    @(negedge CLK); #1;
    total++; if (mc_done !== 1'b1 || mc_done_rd !== 5'd12) begin bad++; $display("[TB] FAIL b2b_second got=%b/%0d want=1/12", mc_done, mc_done_rd); end
    @(negedge CLK); #1;
    total++; if (mc_done !== 1'b0) begin bad++; $display("[TB] FAIL b2b_after got=%b want=0", mc_done); end
  endtask

  task automatic test_reset_midop();
    int nDone;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK); issueMc(AW'(20 + k), 4'd15);
    end
    @(negedge CLK); idle(); ex_valid = 1'b1; ex_rs = {5'd21, 5'd0}; ex_rs_used = 2'b10; #1;
    total++; if (stall !== 1'b1) begin bad++; $display("[TB] FAIL midrst_pre_stall got=%b want=1", stall); end
    @(negedge CLK); RSTn = 1'b0; idle();
    @(negedge CLK); RSTn = 1'b1; ex_valid = 1'b1; ex_rs = {5'd21, 5'd0}; ex_rs_used = 2'b10; ex_wen = 1'b1; ex_rd = 5'd20; #1;
    total++; if (sb_full !== 1'b0) begin bad++; $display("[TB] FAIL midrst_sb_full got=%b want=0", sb_full); end
    total++; if (mc_done !== 1'b0) begin bad++; $display("[TB] FAIL midrst_mc_done got=%b want=0", mc_done); end
    total++; if (stall_cnt !== 4'd0) begin bad++; $display("[TB] FAIL midrst_stall_cnt got=%0d want=0", stall_cnt); end
    total++; if (stall !== 1'b0) begin bad++; $display("[TB] FAIL midrst_consumer got=%b want=0", stall); end
    nDone = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK); idle(); #1;
      if (mc_done === 1'b1) nDone++;
    end
    total++; if (nDone !== 0) begin bad++; $display("[TB] FAIL midrst_ghost_done got=%0d want=0", nDone); end
  endtask

  task automatic test_random();
    ExpT e;
    for (int c = 0; c < 400; c++) begin
      @(negedge CLK);
      RSTn        = ($urandom_range(0, 63) != 0);
      ex_valid    = ($urandom_range(0, 3) != 0);
      ex_rs       = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
      ex_rs_used  = NS'($urandom_range(0, 3));
      ex_rd       = AW'($urandom_range(0, 7));
      mc_issue    = ($urandom_range(0, 2) == 0);
      ex_wen      = mc_issue ? 1'b1 : 1'($urandom_range(0, 1));
      mc_lat      = LW'($urandom_range(0, 7));
      mem_rd      = AW'($urandom_range(0, 7));
      mem_wen     = 1'($urandom_range(0, 1));
      mem_is_load = ($urandom_range(0, 3) == 0);
      wb_rd       = AW'($urandom_range(0, 7));
      wb_wen      = 1'($urandom_range(0, 1));
      #1;
      e = modelEval();
      total++; if (fwd_sel !== e.sel) begin bad++; $display("[TB] FAIL rnd_fwd_sel cyc=%0d got=%b want=%b", c, fwd_sel, e.sel); end
      total++; if (stall !== e.stall) begin bad++; $display("[TB] FAIL rnd_stall cyc=%0d got=%b want=%b", c, stall, e.stall); end
      total++; if (bubble !== e.stall) begin bad++; $display("[TB] FAIL rnd_bubble cyc=%0d got=%b want=%b", c, bubble, e.stall); end
      total++; if (mc_done !== e.done) begin bad++; $display("[TB] FAIL rnd_mc_done cyc=%0d got=%b want=%b", c, mc_done, e.done); end
      total++; if (mc_done_rd !== e.doneRd) begin bad++; $display("[TB] FAIL rnd_mc_done_rd cyc=%0d got=%0d want=%0d", c, mc_done_rd, e.doneRd); end
      total++; if (sb_full !== e.full) begin bad++; $display("[TB] FAIL rnd_sb_full cyc=%0d got=%b want=%b", c, sb_full, e.full); end
      total++; if (int'(stall_cnt) !== mStallCnt) begin bad++; $display("[TB] FAIL rnd_stall_cnt cyc=%0d got=%0d want=%0d", c, stall_cnt, mStallCnt); end
    end
    RSTn = 1'b1;
  endtask

  task automatic test_saturation();
    @(negedge CLK); RSTn = 1'b0; idle();
    @(negedge CLK); RSTn = 1'b1;
    ex_valid = 1'b1; ex_rs = {5'd0, 5'd4}; ex_rs_used = 2'b01;
    mem_rd = 5'd4; mem_wen = 1'b1; mem_is_load = 1'b1;
    #1;
    total++; if (stall_cnt !== 4'd0) begin bad++; $display("[TB] FAIL sat_start got=%0d want=0", stall_cnt); end
    for (int i = 1; i <= 20; i++) begin
      @(negedge CLK); #1;
      if (i == 10) begin
        total++; if (stall_cnt !== 4'd10) begin bad++; $display("[TB] FAIL sat_mid got=%0d want=10", stall_cnt); end
      end
    end
    total++; if (stall_cnt !== 4'hF) begin bad++; $display("[TB] FAIL sat_hold got=%0d want=15", stall_cnt); end
    total++; if (stall !== 1'b1) begin bad++; $display("[TB] FAIL sat_stall got=%b want=1", stall); end
  endtask

  // Run every scenario in order, then report.
  initial begin
    idle();
    test_reset();
    test_priority();
    test_load_use();
    test_mc_raw();
    test_waw_full();
    test_back_to_back();
    test_reset_midop();
    test_random();
    test_saturation();
    @(negedge CLK); idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
